// File: rtl/latch_bank_write_sequencer_pkg.sv
// Shared constants for the latch-bank write sequencer: FSM state encoding and
// the legal parameter ranges checked at elaboration time.
package latch_bank_write_sequencer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam int NREQ_MIN  = 2;
  localparam int NREQ_MAX  = 8;
  localparam int DEPTH_MIN = 1;

  function automatic bit params_legal(int nreq, int depth, int aw);
    return (nreq >= NREQ_MIN) && (nreq <= NREQ_MAX) &&
           (depth >= DEPTH_MIN) && (depth <= (1 << aw));
  endfunction

endpackage

// File: rtl/latch_bank_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: searches req_i starting at ptr_i, wrapping
// from NREQ-1 back to 0, and reports the first requester found.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            any_req_o
);

  logic [NREQ-1:0] rot;
  logic [IW:0]     sum;
  logic            found;

  // NOTE: every signal written here gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    // Rotating right by ptr_i puts the highest-priority requester at bit 0.
    rot       = NREQ'({req_i, req_i} >> ptr_i);
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + (IW+1)'(i);
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        gnt_idx_o = IW'(sum);
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/latch_bank_write_sequencer.sv
// Arbitrates write requests onto a shared bank of transparent latches and runs a
// registered setup/strobe/hold sequence so latch data is stable around the enable.
module latch_bank_write_sequencer
  import latch_bank_write_sequencer_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 6,
  parameter int AW    = 3,
  parameter int DW    = 8,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic               busy,
  output logic [IW-1:0]      gnt_id,
  output logic [DW-1:0]      lat_d,
  output logic [DEPTH-1:0]   lat_en
);

  if (!params_legal(NREQ, DEPTH, AW)) begin : g_bad_params
    $error("latch_bank_write_sequencer: illegal NREQ/DEPTH/AW combination");
  end

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]       state_q,  state_d;
  logic [IW-1:0]    ptr_q,    ptr_d;
  logic [IW-1:0]    gnt_q,    gnt_d;
  logic [AW-1:0]    addr_q,   addr_d;
  logic [DW-1:0]    lat_d_q,  lat_d_d;
  logic [DEPTH-1:0] lat_en_q, lat_en_d;
  logic [NREQ-1:0]  ack_q,    ack_d;
  logic             err_q,    err_d;
  logic             busy_q,   busy_d;

  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             in_range;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_idx_o (arb_idx),
    .any_req_o (arb_any)
  );

  assign in_range = ({1'b0, addr_q} < DEPTH_W);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    lat_d_d  = lat_d_q;
    lat_en_d = '0;
    ack_d    = '0;
    err_d    = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        // The winner's address and data are frozen here; later input changes are ignored.
        if (arb_any) begin
          state_d = ST_SETUP;
          gnt_d   = arb_idx;
          addr_d  = addr[arb_idx*AW +: AW];
          lat_d_d = data[arb_idx*DW +: DW];
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        // Decode from the captured address only; an out-of-range address matches no word.
        for (int n = 0; n < DEPTH; n++) begin
          lat_en_d[n] = (addr_q == AW'(n));
        end
      end
      ST_STROBE: begin
        state_d      = ST_HOLD;
        ack_d[gnt_q] = 1'b1;
        err_d        = !in_range;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ptr_d   = (gnt_q == IW'(NREQ-1)) ? '0 : gnt_q + IW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values; the asynchronous reset drops lat_en without a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_q;
  assign lat_d  = lat_d_q;
  assign lat_en = lat_en_q;

endmodule

// File: tb/tb_latch_bank_write_sequencer.sv
// Scoreboard bench for latch_bank_write_sequencer: expected writes are queued when
// requests are driven and matched against every strobe and ack the DUT produces.
module tb_latch_bank_write_sequencer;

  localparam int NREQ  = 4;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int IW    = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [NREQ-1:0]    req   = '0;
  logic [NREQ*AW-1:0] addr  = '0;
  logic [NREQ*DW-1:0] data  = '0;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic               busy;
  logic [IW-1:0]      gnt_id;
  logic [DW-1:0]      lat_d;
  logic [DEPTH-1:0]   lat_en;

  typedef struct {
    logic [NREQ-1:0]  ack;
    logic             err;
    logic [DW-1:0]    d;
    logic [DEPTH-1:0] en;
  } exp_t;

  exp_t             sb_q[$];
  int               ack_cyc_q[$];
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  logic [DEPTH-1:0] prev_en  = '0;

  latch_bank_write_sequencer #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .addr   (addr),
    .data   (data),
    .ack    (ack),
    .err    (err),
    .busy   (busy),
    .gnt_id (gnt_id),
    .lat_d  (lat_d),
    .lat_en (lat_en)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic exp_t mk_exp(int id, int a, logic [DW-1:0] d);
    exp_t e;
    e.ack = NREQ'(1 << id);
    e.err = (a >= DEPTH);
    e.d   = d;
    e.en  = (a < DEPTH) ? DEPTH'(1 << a) : '0;
    return e;
  endfunction

  task automatic set_req(int id, int a, logic [DW-1:0] d);
    addr[id*AW +: AW] = AW'(a);
    data[id*DW +: DW] = d;
    req[id]           = 1'b1;
  endtask

  // Waits until the scoreboard is empty and the DUT is idle, dropping each
  // requester's req once it has been acknowledged.
  task automatic drain(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock); #1;
      if (ack !== '0) req = req & ~ack;
      if (sb_q.size() == 0 && busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Scoreboard consumer: every strobe and every ack must match the oldest pending write.
  always @(negedge clock) begin : monitor
    exp_t             e;
    logic [DEPTH-1:0] want_en;
    want_en = (sb_q.size() > 0) ? sb_q[0].en : '0;
    if (lat_en !== '0) begin
      checks++;
      if (sb_q.size() == 0 || lat_en !== want_en || prev_en !== '0) begin
        failures++;
        $display("FAIL strobe: lat_en=%b expected=%b prev_cycle=%b pending=%0d",
                 lat_en, want_en, prev_en, sb_q.size());
      end
    end
    if (ack !== '0) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL ack_unexpected: ack=%b err=%b with no write pending", ack, err);
      end else begin
        e = sb_q.pop_front();
        ack_cyc_q.push_back(cyc);
        if (ack !== e.ack || err !== e.err || lat_d !== e.d || prev_en !== e.en || lat_en !== '0) begin
          failures++;
          $display("FAIL ack_scoreboard: ack=%b err=%b lat_d=%h strobe=%b lat_en=%b expected ack=%b err=%b lat_d=%h strobe=%b lat_en=0",
                   ack, err, lat_d, prev_en, lat_en, e.ack, e.err, e.d, e.en);
        end
      end
    end else if (err !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL err_without_ack: err=%b expected 0", err);
    end
    prev_en = lat_en;
  end

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    checks++;
    if (lat_en !== '0) begin failures++; $display("FAIL reset_lat_en: got %b expected 0", lat_en); end
    checks++;
    if (lat_d !== '0 || ack !== '0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_data_ack: lat_d=%h ack=%b err=%b expected all 0", lat_d, ack, err);
    end
    checks++;
    if (busy !== 1'b0 || gnt_id !== '0) begin
      failures++; $display("FAIL reset_busy_gnt: busy=%b gnt_id=%0d expected 0/0", busy, gnt_id);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || lat_en !== '0 || ack !== '0) begin
      failures++; $display("FAIL reset_held: busy=%b lat_en=%b ack=%b expected 0", busy, lat_en, ack);
    end
    @(negedge clock) reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || lat_en !== '0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b lat_en=%b expected 0", busy, lat_en);
    end
  endtask

  task automatic test_contention();
    bit to;
    @(negedge clock);
    ack_cyc_q.delete();
    for (int id = 0; id < NREQ; id++) begin
      set_req(id, id, DW'(8'h10 + id));
      sb_q.push_back(mk_exp(id, id, DW'(8'h10 + id)));
    end
    drain(40, to);
    checks++;
    if (to) begin failures++; $display("FAIL contention_timeout: pending=%0d busy=%b", sb_q.size(), busy); end
    checks++;
    if (ack_cyc_q.size() != NREQ) begin
      failures++; $display("FAIL contention_ack_count: got %0d expected %0d", ack_cyc_q.size(), NREQ);
    end
    for (int i = 1; i < ack_cyc_q.size(); i++) begin
      checks++;
      if (ack_cyc_q[i] - ack_cyc_q[i-1] != 4) begin
        failures++; $display("FAIL contention_spacing: ack %0d came %0d cycles after previous, expected 4",
                             i, ack_cyc_q[i] - ack_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_single_write();
    @(negedge clock);
    set_req(2, 5, 8'hA5);
    sb_q.push_back(mk_exp(2, 5, 8'hA5));
    @(negedge clock); #1;
    checks++;
    if (lat_d !== 8'hA5 || lat_en !== '0 || busy !== 1'b1 || gnt_id !== 2'd2) begin
      failures++; $display("FAIL single_setup: lat_d=%h lat_en=%b busy=%b gnt_id=%0d expected A5/0/1/2",
                           lat_d, lat_en, busy, gnt_id);
    end
    addr[2*AW +: AW] = 3'd0;
    data[2*DW +: DW] = 8'hFF;
    @(negedge clock); #1;
    checks++;
    if (lat_en !== 6'b100000 || lat_d !== 8'hA5) begin
      failures++; $display("FAIL single_strobe: lat_en=%b lat_d=%h expected 100000/A5", lat_en, lat_d);
    end
    @(negedge clock); #1;
    checks++;
    if (ack !== 4'b0100 || err !== 1'b0 || lat_en !== '0) begin
      failures++; $display("FAIL single_hold: ack=%b err=%b lat_en=%b expected 0100/0/0", ack, err, lat_en);
    end
    req[2] = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (busy !== 1'b0 || lat_d !== 8'hA5 || ack !== '0) begin
      failures++; $display("FAIL single_idle: busy=%b lat_d=%h ack=%b expected 0/A5/0", busy, lat_d, ack);
    end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL single_pending: %0d writes left, expected 0", sb_q.size()); end
  endtask

  task automatic test_pointer_wrap();
    bit to;
    @(negedge clock);
    set_req(3, 1, 8'h11);
    sb_q.push_back(mk_exp(3, 1, 8'h11));
    drain(12, to);
    checks++;
    if (to) begin failures++; $display("FAIL wrap_first_timeout: pending=%0d", sb_q.size()); end
    set_req(0, 0, 8'h22);
    set_req(3, 4, 8'h33);
    sb_q.push_back(mk_exp(0, 0, 8'h22));
    sb_q.push_back(mk_exp(3, 4, 8'h33));
    drain(20, to);
    checks++;
    if (to) begin failures++; $display("FAIL wrap_pair_timeout: pending=%0d", sb_q.size()); end
  endtask

  task automatic test_out_of_range();
    bit to;
    @(negedge clock);
    set_req(1, 6, 8'h5A);
    sb_q.push_back(mk_exp(1, 6, 8'h5A));
    @(negedge clock);
    req[1] = 1'b0;
    drain(12, to);
    checks++;
    if (to) begin failures++; $display("FAIL oor_addr6_timeout: pending=%0d", sb_q.size()); end
    set_req(1, 7, 8'hC3);
    sb_q.push_back(mk_exp(1, 7, 8'hC3));
    drain(12, to);
    checks++;
    if (to) begin failures++; $display("FAIL oor_addr7_timeout: pending=%0d", sb_q.size()); end
  endtask

  task automatic test_rotation();
    bit to;
    @(negedge clock);
    set_req(0, 2, 8'h40);
    set_req(1, 3, 8'h41);
    set_req(3, 5, 8'h43);
    sb_q.push_back(mk_exp(3, 5, 8'h43));
    sb_q.push_back(mk_exp(0, 2, 8'h40));
    sb_q.push_back(mk_exp(1, 3, 8'h41));
    drain(30, to);
    checks++;
    if (to) begin failures++; $display("FAIL rotation_timeout: pending=%0d", sb_q.size()); end
  endtask

  task automatic test_reset_mid_strobe();
    bit to;
    @(negedge clock);
    set_req(2, 3, 8'h77);
    sb_q.push_back(mk_exp(2, 3, 8'h77));
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); #1;
      if (lat_en !== '0) break;
    end
    checks++;
    if (lat_en !== 6'b001000) begin failures++; $display("FAIL midreset_reach_strobe: lat_en=%b expected 001000", lat_en); end
    reset = 1'b1;
    req   = '0;
    #1;
    checks++;
    if (lat_en !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_async: lat_en=%b busy=%b expected 0/0 before next edge", lat_en, busy);
    end
    sb_q.delete();
    @(posedge clock); #1;
    checks++;
    if (ack !== '0 || err !== 1'b0) begin failures++; $display("FAIL midreset_no_ack: ack=%b err=%b expected 0", ack, err); end
    @(negedge clock) reset = 1'b0;
    set_req(0, 0, 8'h0F);
    set_req(2, 2, 8'hF0);
    sb_q.push_back(mk_exp(0, 0, 8'h0F));
    sb_q.push_back(mk_exp(2, 2, 8'hF0));
    drain(20, to);
    checks++;
    if (to) begin failures++; $display("FAIL midreset_resume_timeout: pending=%0d", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_pointer_wrap();
    test_out_of_range();
    test_rotation();
    test_reset_mid_strobe();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
